linear_weight_update: RTL and testbench
=======================================

Name: linear_weight_update

Overview:
- Downstream consumer of the linear weight-gradient stage: reads the gradient tensor that stage writes, reads the current weight tensor, and writes the updated weights W' = W - ((lr * G) >>> LR_SHIFT) to an output tensor region.
- All three tensors use the standard layout: word0 = ndims (must be 2), word1 = dim0, word2 = dim1, then dim0*dim1 row-major 32-bit signed data words.
- Talks to memory through three mem_handle-style channels: w (read), g (read), o (write).

Parameters:
LR_SHIFT, 8, fixed-point fraction bits of lr (lr = 256 means 1.0).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
go  input  1  start request, sampled in IDLE
lr  input  32  signed learning rate, Q(32-LR_SHIFT).LR_SHIFT, sampled when go is accepted
done  output  1  high while in DONE
error  output  1  high while in ERR
w_region_begin, g_region_begin, o_region_begin  input  32 each  tensor base addresses
w_ptr, g_ptr, o_ptr  output  32 each  current word address
w_r_en/w_avail, g_r_en/g_avail  output  1 each  read request; both signals of a pair driven identically
o_w_en/o_avail  output  1 each  write request; both signals driven identically
o_data_store  output  32  write data
w_data_load, g_data_load  input  32 each  read data, valid in the cycle the channel's done is high
w_done, g_done, o_done  input  1 each  one-cycle completion pulse per transaction

Behaviour:
- Reset: synchronous, active-high, one cycle.
  - All outputs 0; state IDLE.
  - Any in-flight request is abandoned, including when reset occurs mid-operation.
- Channel handshake:
  - Raise r_en/w_en and avail; hold ptr and data_store stable until done.
  - In the done cycle, capture data_load (reads) and drop the request at the next edge.
  - Advance ptr by 1 at the same edge.
  - Never issue two outstanding requests on one channel.
- Concurrent reads: w and g run in parallel. Each channel latches its own word and drops its own request on its own done. The FSM advances only when both words are captured; done pulses may arrive in different cycles or the same cycle.
- States and transitions:
  - IDLE -> HDR when go; latch lr; load each ptr from its region_begin.
  - HDR: read 3 header words from w and g concurrently (word counter 0..2) -> CHECK.
  - CHECK (1 cycle):
    - ERR if w.ndims != 2, g.ndims != 2, w.dim0 != g.dim0, or w.dim1 != g.dim1.
    - Otherwise latch count = dim0*dim1 (low 32 bits) and element index k = 0 -> WHDR.
  - WHDR: write w's three header words to o sequentially -> ELEM if count != 0, else DONE.
  - ELEM: concurrent read of W[k], G[k] -> CALC.
  - CALC (1 cycle):
    - p = signed 64-bit (G[k] * lr); s = p >>> LR_SHIFT; take s[31:0].
    - o_data_store <= W[k] - s[31:0], wrapping mod 2^32 with no saturation.
    - -> WELEM.
  - WELEM: write o_data_store; on o_done, k <= k+1 -> DONE if k+1 == count, else ELEM.
  - DONE: done = 1; -> IDLE when go == 0.
  - ERR: error = 1, no memory traffic; -> IDLE when go == 0.
- go held high in DONE/ERR does not restart the operation; it must drop for at least one cycle.
- Latency per element with zero-wait memory (done in the cycle after the request): 2 (ELEM) + 1 (CALC) + 2 (WELEM) = 5 cycles.
- No interaction with in-place aliasing: o_region_begin may equal w_region_begin because each W[k] is read before O[k] is written.

Test Plan:
- 2x2 case:
  - Stimulus: W = {2,2,2,1000,-500,0,7}, G = {2,2,2,256,512,-256,0}, lr = 256, zero-wait memory.
  - Required: o = {2,2,2,744,-1012,256,7}; done rises; o_ptr = o_region_begin+7.
- Shift rounding:
  - Stimulus: W = {2,1,1,10}, G = {2,1,1,-3}, lr = 128.
  - Required: s = -384>>>8 = -2, so o data = 12.
- Dimension mismatch:
  - Stimulus: W dims 2x3, G dims 3x2.
  - Required: error = 1 after CHECK; no o_w_en ever asserted; returns to IDLE after go drops.
- Skewed dones:
  - Stimulus: w_done 3 cycles after request, g_done 7 cycles after request, over the 2x2 case.
  - Required: identical o contents to the 2x2 case; each read request drops on its own done.
- Zero-size tensor:
  - Stimulus: W = G = {2,0,5}.
  - Required: o = {2,0,5}, no element reads, done.
- Reset mid-operation:
  - Stimulus: rst asserted during WELEM of element 1.
  - Required: next cycle all requests low, done/error low, state IDLE; a fresh go then reruns the full sequence correctly.

Source files
------------

// File: rtl/linear_weight_update.sv
// Weight update engine: O = W - ((lr * G) >>> LR_SHIFT) over 2-D tensors,
// with concurrent header and element reads on the w/g channels and sequential writes on o.
module linear_weight_update #(
    parameter int LR_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] lr,
    output logic        done,
    output logic        error,
    input  logic [31:0] w_region_begin,
    input  logic [31:0] g_region_begin,
    input  logic [31:0] o_region_begin,
    output logic [31:0] w_ptr,
    output logic [31:0] g_ptr,
    output logic [31:0] o_ptr,
    output logic        w_r_en,
    output logic        w_avail,
    output logic        g_r_en,
    output logic        g_avail,
    output logic        o_w_en,
    output logic        o_avail,
    output logic [31:0] o_data_store,
    input  logic [31:0] w_data_load,
    input  logic [31:0] g_data_load,
    input  logic        w_done,
    input  logic        g_done,
    input  logic        o_done
);
    typedef enum logic [3:0] {
        IDLE, HDR, CHECK, WHDR, ELEM, CALC, WELEM, FINISHED, FAILED
    } state_t;

    state_t             state;
    logic [31:0]        lr_q;
    logic [1:0]         cnt;
    logic [31:0]        k;
    logic [31:0]        count;
    logic [31:0]        w_hdr [3];
    logic [31:0]        g_hdr [3];
    logic [31:0]        w_word;
    logic [31:0]        g_word;
    logic               w_got;
    logic               g_got;

    logic               w_fire, g_fire, o_fire, both;
    logic [31:0]        w_val, g_val;
    logic signed [63:0] g_ext, lr_ext, prod, shifted;

    assign w_avail = w_r_en;
    assign g_avail = g_r_en;
    assign o_avail = o_w_en;

    assign w_fire = w_r_en & w_done;
    assign g_fire = g_r_en & g_done;
    assign o_fire = o_w_en & o_done;
    // A channel counts as complete if it finished earlier or finishes this cycle.
    assign both   = (w_got | w_fire) & (g_got | g_fire);
    assign w_val  = w_fire ? w_data_load : w_word;
    assign g_val  = g_fire ? g_data_load : g_word;

    assign g_ext   = {{32{g_word[31]}}, g_word};
    assign lr_ext  = {{32{lr_q[31]}}, lr_q};
    assign prod    = g_ext * lr_ext;
    assign shifted = prod >>> LR_SHIFT;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values;
    // later assignments in this block deliberately override the channel bookkeeping above them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lr_q         <= '0;
            cnt          <= '0;
            k            <= '0;
            count        <= '0;
            w_word       <= '0;
            g_word       <= '0;
            w_got        <= 1'b0;
            g_got        <= 1'b0;
            w_ptr        <= '0;
            g_ptr        <= '0;
            o_ptr        <= '0;
            w_r_en       <= 1'b0;
            g_r_en       <= 1'b0;
            o_w_en       <= 1'b0;
            o_data_store <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                w_hdr[i] <= '0;
                g_hdr[i] <= '0;
            end
        end else begin
            if (w_fire) begin
                w_word <= w_data_load;
                w_r_en <= 1'b0;
                w_ptr  <= w_ptr + 32'd1;
                w_got  <= 1'b1;
            end
            if (g_fire) begin
                g_word <= g_data_load;
                g_r_en <= 1'b0;
                g_ptr  <= g_ptr + 32'd1;
                g_got  <= 1'b1;
            end
            if (o_fire) begin
                o_w_en <= 1'b0;
                o_ptr  <= o_ptr + 32'd1;
            end

            case (state)
                IDLE: if (go) begin
                    lr_q   <= lr;
                    w_ptr  <= w_region_begin;
                    g_ptr  <= g_region_begin;
                    o_ptr  <= o_region_begin;
                    w_r_en <= 1'b1;
                    g_r_en <= 1'b1;
                    w_got  <= 1'b0;
                    g_got  <= 1'b0;
                    cnt    <= '0;
                    state  <= HDR;
                end
                HDR: begin
                    if (both) begin
                        w_hdr[cnt] <= w_val;
                        g_hdr[cnt] <= g_val;
                        w_got      <= 1'b0;
                        g_got      <= 1'b0;
                        if (cnt == 2'd2) state <= CHECK;
                        else             cnt   <= cnt + 2'd1;
                    end else if (!w_r_en && !w_got && !g_r_en && !g_got) begin
                        w_r_en <= 1'b1;
                        g_r_en <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_hdr[0] != 32'd2 || g_hdr[0] != 32'd2 ||
                        w_hdr[1] != g_hdr[1] || w_hdr[2] != g_hdr[2]) begin
                        error <= 1'b1;
                        state <= FAILED;
                    end else begin
                        count        <= w_hdr[1] * w_hdr[2];
                        k            <= '0;
                        cnt          <= '0;
                        o_w_en       <= 1'b1;
                        o_data_store <= w_hdr[0];
                        state        <= WHDR;
                    end
                end
                WHDR: begin
                    if (o_fire) begin
                        if (cnt != 2'd2) begin
                            cnt <= cnt + 2'd1;
                        end else if (count == '0) begin
                            done  <= 1'b1;
                            state <= FINISHED;
                        end else begin
                            w_r_en <= 1'b1;
                            g_r_en <= 1'b1;
                            state  <= ELEM;
                        end
                    end else if (!o_w_en) begin
                        o_w_en       <= 1'b1;
                        o_data_store <= w_hdr[cnt];
                    end
                end
                ELEM: if (both) begin
                    w_got <= 1'b0;
                    g_got <= 1'b0;
                    state <= CALC;
                end
                CALC: begin
                    o_data_store <= w_word - shifted[31:0];
                    o_w_en       <= 1'b1;
                    state        <= WELEM;
                end
                WELEM: if (o_fire) begin
                    k <= k + 32'd1;
                    if (k + 32'd1 == count) begin
                        done  <= 1'b1;
                        state <= FINISHED;
                    end else begin
                        w_r_en <= 1'b1;
                        g_r_en <= 1'b1;
                        state  <= ELEM;
                    end
                end
                FINISHED: if (!go) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                FAILED: if (!go) begin
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_linear_weight_update.sv
// Bench for linear_weight_update: latency-configurable memory responders plus an
// arithmetic reference model of the expected output tensor.
module tb_linear_weight_update;
    localparam int WB = 0, GB = 64, OB = 128;

    logic        clk = 1'b0, rst = 1'b1, go = 1'b0;
    logic [31:0] lr = '0;
    logic        done, error;
    logic [31:0] w_ptr, g_ptr, o_ptr, o_data_store;
    logic        w_r_en, w_avail, g_r_en, g_avail, o_w_en, o_avail;
    logic [31:0] w_data_load = '0, g_data_load = '0;
    logic        w_done = 1'b0, g_done = 1'b0, o_done = 1'b0;

    int mem [0:255];
    int w_lat = 1, g_lat = 1, o_lat = 1;
    int wc = 0, gc = 0, oc = 0;
    int w_reads = 0, violations = 0;
    bit o_seen = 0;
    int n_checks = 0, n_pass = 0;

    linear_weight_update dut (
        .clk(clk), .rst(rst), .go(go), .lr(lr), .done(done), .error(error),
        .w_region_begin(WB), .g_region_begin(GB), .o_region_begin(OB),
        .w_ptr(w_ptr), .g_ptr(g_ptr), .o_ptr(o_ptr),
        .w_r_en(w_r_en), .w_avail(w_avail), .g_r_en(g_r_en), .g_avail(g_avail),
        .o_w_en(o_w_en), .o_avail(o_avail), .o_data_store(o_data_store),
        .w_data_load(w_data_load), .g_data_load(g_data_load),
        .w_done(w_done), .g_done(g_done), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory responders: done pulses `lat` cycles after a request is first seen.
    always @(negedge clk) begin
        if (w_avail !== w_r_en || g_avail !== g_r_en || o_avail !== o_w_en) violations++;
        if (rst) begin
            w_done = 0; g_done = 0; o_done = 0; wc = 0; gc = 0; oc = 0;
        end else begin
            if (w_done) begin
                if (w_r_en) violations++;
                w_done = 0; wc = 0;
            end else if (w_r_en) begin
                if (wc >= w_lat) begin
                    w_done = 1; w_data_load = mem[w_ptr[7:0]]; w_reads++;
                end else wc++;
            end
            if (g_done) begin
                if (g_r_en) violations++;
                g_done = 0; gc = 0;
            end else if (g_r_en) begin
                if (gc >= g_lat) begin
                    g_done = 1; g_data_load = mem[g_ptr[7:0]];
                end else gc++;
            end
            if (o_w_en) o_seen = 1;
            if (o_done) begin
                if (o_w_en) violations++;
                o_done = 0; oc = 0;
            end else if (o_w_en) begin
                if (oc >= o_lat) begin
                    o_done = 1; mem[o_ptr[7:0]] = o_data_store;
                end else oc++;
            end
        end
    end

    task automatic load(input int base, input int words[$]);
        foreach (words[i]) mem[base + i] = words[i];
    endtask

    task automatic run_case(input string name, input int wq[$], input int gq[$], input int lr_v,
                            input int wl, input int gl, input int ol);
        bit exp_err;
        int n;
        int exp_o[$];
        longint p;
        for (int i = 0; i < 64; i++) mem[OB + i] = 32'h5A5A_5A5A;
        load(WB, wq);
        load(GB, gq);
        w_lat = wl; g_lat = gl; o_lat = ol;
        w_reads = 0; violations = 0; o_seen = 0;

        exp_err = (wq[0] != 2) || (gq[0] != 2) || (wq[1] != gq[1]) || (wq[2] != gq[2]);
        n = exp_err ? 0 : wq[1] * wq[2];
        for (int i = 0; i < 3; i++) exp_o.push_back(wq[i]);
        for (int i = 0; i < n; i++) begin
            p = longint'(gq[3 + i]) * longint'(lr_v);
            exp_o.push_back(wq[3 + i] - int'(p >>> 8));
        end

        lr = lr_v;
        go = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (exp_err) begin
            check({name, " error"}, error, 1);
            check({name, " no_write"}, o_seen, 0);
            check({name, " hdr_reads"}, w_reads, 3);
        end else begin
            check({name, " done"}, done, 1);
            foreach (exp_o[i]) check($sformatf("%s o[%0d]", name, i), mem[OB + i], exp_o[i]);
            check({name, " o_ptr"}, o_ptr, OB + 3 + n);
            check({name, " w_reads"}, w_reads, 3 + n);
        end
        repeat (3) @(negedge clk);
        check({name, " held"}, {done, error}, exp_err ? 2'b01 : 2'b10);
        go = 0;
        repeat (2) @(negedge clk);
        check({name, " idle"}, {done, error, w_r_en, g_r_en, o_w_en}, 0);
        check({name, " handshake"}, violations, 0);
    endtask

    int w22[$] = '{2, 2, 2, 1000, -500, 0, 7};
    int g22[$] = '{2, 2, 2, 256, 512, -256, 0};

    initial begin
        int wq[$], gq[$];
        int d0, d1;
        bit hit;
        repeat (2) @(negedge clk);
        check("reset outputs", {done, error, w_r_en, g_r_en, o_w_en, w_avail, g_avail, o_avail}, 0);
        check("reset ptrs", {w_ptr, o_ptr}, 0);
        rst = 0;
        @(negedge clk);

        run_case("2x2", w22, g22, 256, 1, 1, 1);
        run_case("rounding", '{2, 1, 1, 10}, '{2, 1, 1, -3}, 128, 1, 1, 1);
        run_case("mismatch", '{2, 2, 3, 1, 2, 3, 4, 5, 6}, '{2, 3, 2, 1, 2, 3, 4, 5, 6}, 256, 1, 1, 1);
        run_case("ndims", '{3, 1, 1, 5}, '{3, 1, 1, 5}, 256, 2, 1, 1);
        run_case("skewed", w22, g22, 256, 3, 7, 1);
        run_case("skewed_rev", w22, g22, 256, 6, 2, 3);
        run_case("zero", '{2, 0, 5}, '{2, 0, 5}, 256, 1, 1, 1);

        // Reset while element 1 is being written, then rerun from scratch.
        load(WB, w22);
        load(GB, g22);
        w_lat = 1; g_lat = 1; o_lat = 2;
        lr = 256;
        go = 1;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_w_en && o_ptr == OB + 4) begin hit = 1; break; end
        end
        check("mid reached WELEM1", hit, 1);
        rst = 1; go = 0;
        @(negedge clk);
        check("mid reset reqs", {w_r_en, g_r_en, o_w_en, done, error}, 0);
        check("mid reset ptrs", {w_ptr, g_ptr, o_ptr, o_data_store}, 0);
        rst = 0;
        @(negedge clk);
        run_case("after_reset", w22, g22, 256, 1, 1, 1);

        for (int t = 0; t < 5; t++) begin
            d0 = $urandom_range(1, 4);
            d1 = $urandom_range(1, 4);
            wq = '{2, d0, d1};
            gq = '{2, d0, d1};
            for (int i = 0; i < d0 * d1; i++) begin
                wq.push_back(int'($urandom));
                gq.push_back(int'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 2000) - 1000));
            end
            run_case($sformatf("rand%0d", t), wq, gq, int'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 1024) - 512),
                     $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
